// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall detection
// with a private EX/MEM, MEM/WB destination shadow and debug counters.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [REG_AW-1:0] idex_rs_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic [REG_AW-1:0] idex_dst_i,
  input  logic              idex_wr_i,
  input  logic              idex_mrd_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
);

  typedef struct packed {
    logic              wr;
    logic [REG_AW-1:0] dst;
  } shadow_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  shadow_t          exmem_q;
  shadow_t          memwb_q;
  shadow_t          exmem_d;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall;
  logic             any_fwd;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  // a write to r0 never counts as a producer
  function automatic logic hit(
    input shadow_t           s,
    input logic [REG_AW-1:0] src
  );
    return s.wr && (s.dst != '0) && (s.dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input shadow_t           ex,
    input shadow_t           mem,
    input logic [REG_AW-1:0] src
  );
    logic ex_hit;
    logic mem_hit;
    logic [1:0] sel;
    ex_hit  = hit(ex, src);
    mem_hit = hit(mem, src);
    sel     = SEL_RF;
    unique case (1'b1)
      ex_hit:             sel = SEL_MEM;
      mem_hit && !ex_hit: sel = SEL_WB;
      default:            sel = SEL_RF;
    endcase
    return sel;
  endfunction

  always_comb begin
    fwd_a   = fwd_sel(exmem_q, memwb_q, idex_rs_i);
    fwd_b   = fwd_sel(exmem_q, memwb_q, idex_rt_i);
    any_fwd = (fwd_a != SEL_RF) || (fwd_b != SEL_RF);
  end

  always_comb begin
    stall = idex_mrd_i
         && (idex_dst_i != '0)
         && ((idex_dst_i == ifid_rs_i)
          || (idex_dst_i == ifid_rt_i));
  end

  // the load still moves on, but as a bubble for forwarding
  always_comb begin
    exmem_d.wr  = idex_wr_i & ~stall;
    exmem_d.dst = idex_dst_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (en_i) begin
      exmem_q <= exmem_d;
      memwb_q <= exmem_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (en_i) begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (any_fwd && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
    end
  end

  // reset must win over live ID/EX inputs
  assign fwd_a_o     = rst_i ? SEL_RF : fwd_a;
  assign fwd_b_o     = rst_i ? SEL_RF : fwd_b;
  assign stall_o     = rst_i ? 1'b0 : stall;
  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: history-list model checked every
// negedge plus hand-computed literal checkpoints.
module tb_fwd_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 10;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              en_i;
  logic [REG_AW-1:0] idex_rs_i;
  logic [REG_AW-1:0] idex_rt_i;
  logic [REG_AW-1:0] idex_dst_i;
  logic              idex_wr_i;
  logic              idex_mrd_i;
  logic [REG_AW-1:0] ifid_rs_i;
  logic [REG_AW-1:0] ifid_rt_i;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  fwd_cnt_o;

  fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .idex_rs_i(idex_rs_i), .idex_rt_i(idex_rt_i),
    .idex_dst_i(idex_dst_i), .idex_wr_i(idex_wr_i),
    .idex_mrd_i(idex_mrd_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o), .fwd_cnt_o(fwd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, req);
    end
  endtask

  // model: list of the last two issued writers, newest first
  int h_dst [2];
  bit h_wr  [2];
  int m_stall_cnt;
  int m_fwd_cnt;

  function automatic int exp_sel(input int src);
    for (int k = 0; k < 2; k++)
      if (h_wr[k] && h_dst[k] != 0 && h_dst[k] == src)
        return 2 - k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (rst_i) return 1'b0;
    return idex_mrd_i && idex_dst_i != 0 &&
      (idex_dst_i == ifid_rs_i || idex_dst_i == ifid_rt_i);
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_dst[0] <= 0; h_dst[1] <= 0;
      h_wr[0]  <= 0; h_wr[1]  <= 0;
      m_stall_cnt <= 0;
      m_fwd_cnt   <= 0;
    end else if (en_i) begin
      h_dst[1] <= h_dst[0];
      h_wr[1]  <= h_wr[0];
      h_dst[0] <= int'(idex_dst_i);
      h_wr[0]  <= idex_wr_i && !exp_stall();
      if (exp_stall())
        m_stall_cnt <= (m_stall_cnt < MAXC) ? m_stall_cnt + 1 : MAXC;
      if (exp_sel(int'(idex_rs_i)) != 0 || exp_sel(int'(idex_rt_i)) != 0)
        m_fwd_cnt <= (m_fwd_cnt < MAXC) ? m_fwd_cnt + 1 : MAXC;
    end
  end

  always @(negedge clk_i) begin
    check("m_fwd_a", int'(fwd_a_o), rst_i ? 0 : exp_sel(int'(idex_rs_i)));
    check("m_fwd_b", int'(fwd_b_o), rst_i ? 0 : exp_sel(int'(idex_rt_i)));
    check("m_stall", int'(stall_o), int'(exp_stall()));
    check("m_stall_cnt", int'(stall_cnt_o), m_stall_cnt);
    check("m_fwd_cnt", int'(fwd_cnt_o), m_fwd_cnt);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    idex_rs_i = 0; idex_rt_i = 0; idex_dst_i = 0;
    idex_wr_i = 0; idex_mrd_i = 0;
    ifid_rs_i = 0; ifid_rt_i = 0;
  endtask

  initial begin
    rst_i = 1; en_i = 1;
    idle();
    // reset masks a live load-use pattern
    idex_mrd_i = 1; idex_dst_i = 3; idex_rs_i = 3; ifid_rs_i = 3;
    #1;
    check("rst_stall", int'(stall_o), 0);
    check("rst_fwd_a", int'(fwd_a_o), 0);
    check("rst_fwd_b", int'(fwd_b_o), 0);
    check("rst_scnt", int'(stall_cnt_o), 0);
    check("rst_fcnt", int'(fwd_cnt_o), 0);
    repeat (2) cyc();
    rst_i = 0;
    #1;
    check("rel_stall", int'(stall_o), 1);
    check("rel_fwd_a", int'(fwd_a_o), 0);
    cyc();
    check("rel_scnt", int'(stall_cnt_o), 1);
    idle();

    // EX/MEM then MEM/WB forward of $4
    idex_wr_i = 1; idex_dst_i = 4;
    cyc();
    idex_wr_i = 0; idex_dst_i = 0; idex_rs_i = 4;
    #1 check("t2_exmem", int'(fwd_a_o), 2);
    cyc();
    check("t2_memwb", int'(fwd_a_o), 1);
    cyc();
    check("t2_none", int'(fwd_a_o), 0);
    check("t2_fcnt", int'(fwd_cnt_o), 2);
    idle();

    // back-to-back writers: newest wins
    idex_wr_i = 1; idex_dst_i = 5;
    cyc();
    cyc();
    idex_wr_i = 0; idex_dst_i = 0; idex_rs_i = 5; idex_rt_i = 5;
    #1;
    check("t3_a", int'(fwd_a_o), 2);
    check("t3_b", int'(fwd_b_o), 2);
    cyc();
    check("t3_a_wb", int'(fwd_a_o), 1);
    check("t3_b_wb", int'(fwd_b_o), 1);
    cyc();
    idle();

    // r0 is never forwarded
    idex_wr_i = 1; idex_dst_i = 0;
    cyc();
    idex_wr_i = 0;
    #1 check("t4_ex", int'(fwd_a_o), 0);
    cyc();
    check("t4_wb", int'(fwd_a_o), 0);
    cyc();
    cyc();

    // load-use on rt, then freeze
    idex_mrd_i = 1; idex_wr_i = 1; idex_dst_i = 7; ifid_rt_i = 7;
    #1;
    check("t5_stall", int'(stall_o), 1);
    check("t5_scnt0", int'(stall_cnt_o), 1);
    cyc();
    check("t5_scnt1", int'(stall_cnt_o), 2);
    idle();
    #1 check("t5_bubble", int'(stall_o), 0);
    idex_wr_i = 1; idex_dst_i = 6;
    cyc();
    idex_wr_i = 0; idex_dst_i = 0; idex_rs_i = 6;
    #1 check("t5_pre", int'(fwd_a_o), 2);
    en_i = 0;
    idex_wr_i = 1; idex_dst_i = 8; idex_mrd_i = 1; ifid_rt_i = 8;
    repeat (3) cyc();
    check("t5_hold_fwd", int'(fwd_a_o), 2);
    check("t5_hold_scnt", int'(stall_cnt_o), 2);
    check("t5_hold_fcnt", int'(fwd_cnt_o), 4);
    idle();
    en_i = 1;

    // saturation: stall phase then forward phase
    idex_mrd_i = 1; idex_dst_i = 9; ifid_rs_i = 9;
    repeat ((1 << CNT_W) + 3) cyc();
    check("t6_scnt_sat", int'(stall_cnt_o), MAXC);
    idle();
    idex_wr_i = 1; idex_dst_i = 9; idex_rs_i = 9;
    repeat ((1 << CNT_W) + 3) cyc();
    check("t6_fcnt_sat", int'(fwd_cnt_o), MAXC);
    check("t6_scnt_keep", int'(stall_cnt_o), MAXC);

    // async reset mid-stall
    idex_mrd_i = 1; idex_dst_i = 3; ifid_rs_i = 3;
    #1 check("t7_pre", int'(stall_o), 1);
    #1 rst_i = 1;
    #1;
    check("t7_stall", int'(stall_o), 0);
    check("t7_fwd_a", int'(fwd_a_o), 0);
    check("t7_scnt", int'(stall_cnt_o), 0);
    check("t7_fcnt", int'(fwd_cnt_o), 0);
    cyc();
    rst_i = 0;
    idle();
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
